// File: rtl/xor_frame_parity_pkg.sv
// Shared types and helpers for the streaming XOR frame-parity block.
// The result record is declared inside the top, where DATA_W/CNT_W are in scope.
package xor_frame_parity_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Increment that clamps at max_val; callers keep counter widths at or below 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/xor_frame_parity_acc.sv
// Column accumulator, saturating beat counter and sticky overflow flag for the frame in flight.
// The next-value outputs already fold in the current beat, so the top can capture them on the last beat.
module xor_lane_acc
    import xor_frame_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_col_next,
    output logic [CNT_W-1:0]  o_beats_next,
    output logic              o_ovf_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              w_sat;

    assign w_sat        = (r_cnt == CNT_MAX);
    assign o_col_next   = r_acc ^ i_data;
    assign o_beats_next = CNT_W'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
    assign o_ovf_next   = r_ovf | w_sat;

    // Flush and clear both start a fresh frame; either one wins over a load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_flush || i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_load) begin
            r_acc <= o_col_next;
            r_cnt <= o_beats_next;
            r_ovf <= o_ovf_next;
        end
    end

endmodule

// File: rtl/xor_frame_parity.sv
// Streaming frame folder: XORs each frame's beats into a column word, parity bit and beat count,
// with a one-entry result buffer and valid/ready backpressure on both sides.
module xor_frame_parity
    import xor_frame_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_col,
    output logic              out_par,
    output logic [CNT_W-1:0]  out_beats,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef struct packed {
        logic [DATA_W-1:0] col;
        logic              par;
        logic [CNT_W-1:0]  beats;
        logic              ovf;
    } res_t;

    state_t            r_state;
    state_t            w_state_next;
    res_t              r_res;
    res_t              w_res_new;
    logic              r_out_valid;
    logic              w_out_valid_next;
    logic              w_accept;
    logic              w_flush;
    logic              w_beat;
    logic              w_capture;
    logic [DATA_W-1:0] w_col_next;
    logic [CNT_W-1:0]  w_beats_next;
    logic              w_ovf_next;

    assign in_ready  = (r_state == ACCUM) || out_ready;
    assign w_accept  = in_valid && in_ready;
    // A held result has already cleared the accumulator, so flush only matters while accumulating.
    assign w_flush   = flush && (r_state == ACCUM);
    assign w_beat    = w_accept && !w_flush;
    assign w_capture = w_beat && in_last;

    xor_lane_acc #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (w_capture),
        .i_load       (w_beat),
        .i_flush      (w_flush),
        .i_data       (in_data),
        .o_col_next   (w_col_next),
        .o_beats_next (w_beats_next),
        .o_ovf_next   (w_ovf_next)
    );

    always_comb begin
        w_res_new.col   = w_col_next;
        w_res_new.par   = (^w_col_next) ^ ODD;
        w_res_new.beats = w_beats_next;
        w_res_new.ovf   = w_ovf_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_out_valid_next = r_out_valid;
        case (r_state)
            ACCUM: begin
                if (w_capture) begin
                    w_state_next     = HOLD;
                    w_out_valid_next = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next     = w_capture ? HOLD : ACCUM;
                    w_out_valid_next = w_capture;
                end
            end
            default: begin
                w_state_next     = ACCUM;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_out_valid_next;
            if (w_capture) begin
                r_res <= w_res_new;
            end
        end
    end

    assign out_col   = r_res.col;
    assign out_par   = r_res.par;
    assign out_beats = r_res.beats;
    assign out_ovf   = r_res.ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_xor_frame_parity.sv
// Bench for xor_frame_parity: two instances (even/8-bit count and odd/2-bit count) share stimulus
// and are compared against a frame-level model built from queued beats.
module tb_xor_frame_parity;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid, in_last, flush, out_ready;

    logic       a_in_ready, a_par, a_ovf, a_valid;
    logic [7:0] a_col, a_beats;
    logic       b_in_ready, b_par, b_ovf, b_valid;
    logic [7:0] b_col;
    logic [1:0] b_beats;

    int total = 0;
    int bad   = 0;

    // Model state
    bit         m_hold;
    bit         m_valid;
    logic [7:0] m_frame[$];
    logic [7:0] e_col;
    logic       ea_par, eb_par, ea_ovf, eb_ovf;
    int         ea_beats, eb_beats;

    always #5 clock = ~clock;

    xor_frame_parity #(.DATA_W(8), .CNT_W(8), .ODD(1'b0)) u_a (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(a_in_ready), .flush(flush), .out_col(a_col),
        .out_par(a_par), .out_beats(a_beats), .out_ovf(a_ovf), .out_valid(a_valid),
        .out_ready(out_ready)
    );

    xor_frame_parity #(.DATA_W(8), .CNT_W(2), .ODD(1'b1)) u_b (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(b_in_ready), .flush(flush), .out_col(b_col),
        .out_par(b_par), .out_beats(b_beats), .out_ovf(b_ovf), .out_valid(b_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0;
        m_valid = 0;
        m_frame.delete();
        e_col = 8'h00;
        ea_par = 0; eb_par = 0; ea_ovf = 0; eb_ovf = 0;
        ea_beats = 0; eb_beats = 0;
    endtask

    task automatic model_capture();
        int n;
        e_col = 8'h00;
        foreach (m_frame[i]) e_col = e_col ^ m_frame[i];
        n = m_frame.size();
        ea_par   = ^e_col;
        eb_par   = ~(^e_col);
        ea_beats = (n > 255) ? 255 : n;
        ea_ovf   = (n > 255);
        eb_beats = (n > 3) ? 3 : n;
        eb_ovf   = (n > 3);
        m_frame.delete();
        m_hold  = 1;
        m_valid = 1;
    endtask

    task automatic check_outs();
        check("a_valid", a_valid, m_valid);
        check("a_col",   a_col,   e_col);
        check("a_par",   a_par,   ea_par);
        check("a_beats", a_beats, ea_beats);
        check("a_ovf",   a_ovf,   ea_ovf);
        check("b_valid", b_valid, m_valid);
        check("b_col",   b_col,   e_col);
        check("b_par",   b_par,   eb_par);
        check("b_beats", b_beats, eb_beats);
        check("b_ovf",   b_ovf,   eb_ovf);
    endtask

    // Drive one cycle of inputs, check in_ready, clock it, update the model, check outputs.
    task automatic step(input logic [7:0] d, input bit v, input bit l, input bit f, input bit r);
        bit rdy, acc, fl;
        in_data = d; in_valid = v; in_last = l; flush = f; out_ready = r;
        #1;
        rdy = !m_hold || r;
        check("a_in_ready", a_in_ready, rdy);
        check("b_in_ready", b_in_ready, rdy);
        acc = v && rdy;
        fl  = f && !m_hold;
        @(posedge clock);
        if (m_hold && r) begin
            m_hold = 0;
            m_valid = 0;
        end
        if (fl) m_frame.delete();
        else if (acc) begin
            m_frame.push_back(d);
            if (l) model_capture();
        end
        #1;
        check_outs();
    endtask

    initial begin
        reset_n = 1'b0;
        in_data = 8'h00; in_valid = 0; in_last = 0; flush = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outs();
        reset_n = 1'b1;

        // Three-beat frame
        step(8'h0F, 1, 0, 0, 1);
        step(8'hF0, 1, 0, 0, 1);
        step(8'h01, 1, 1, 0, 1);
        check("t1_col",   a_col, 8'hFE);
        check("t1_par",   a_par, 1'b1);
        check("t1_beats", a_beats, 8'd3);
        check("t1_valid", a_valid, 1'b1);
        step(8'h00, 0, 0, 0, 1);

        // Single beat of zero; odd instance reports parity 1
        step(8'h00, 1, 1, 0, 1);
        check("t2_par_odd",   b_par, 1'b1);
        check("t2_beats_odd", b_beats, 2'd1);
        step(8'h00, 0, 0, 0, 1);

        // Backpressure: held result, in_ready low for 4 cycles
        step(8'h55, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(8'h99, 1, 1, (i == 2), 0);
        check("t3_held_col", a_col, 8'h55);
        step(8'hAA, 1, 1, 0, 1);
        check("t3_next_col",   a_col, 8'hAA);
        check("t3_next_beats", a_beats, 8'd1);
        check("t3_next_valid", a_valid, 1'b1);
        step(8'h00, 0, 0, 0, 1);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) step(8'h01, 1, (i == 4), 0, 1);
        check("t4_beats_sat", b_beats, 2'd3);
        check("t4_ovf_sat",   b_ovf, 1'b1);
        check("t4_beats_wide", a_beats, 8'd5);
        step(8'h00, 0, 0, 0, 1);

        // Flush discards the partial frame and the beat accepted alongside it
        step(8'h33, 1, 0, 0, 1);
        step(8'hFF, 1, 0, 1, 1);
        step(8'h0C, 1, 1, 0, 1);
        check("t5_col",   a_col, 8'h0C);
        check("t5_beats", a_beats, 8'd1);
        step(8'h00, 0, 0, 0, 1);

        // Reset mid-frame
        step(8'h12, 1, 0, 0, 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clock);
        #1;
        check_outs();
        reset_n = 1'b1;
        step(8'h34, 1, 1, 0, 1);
        check("t6_col",   a_col, 8'h34);
        check("t6_beats", a_beats, 8'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(8'($urandom_range(255)), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                 ($urandom_range(9) == 0), ($urandom_range(2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
